uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 130 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Signal bundle between the requesters, the UART TX arbiter and the UART transmitter.
// The slave modport is the arbiter's view; master is the requester/transmitter side.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] din_flat;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   done;
  logic [NREQ-1:0]   err;
  logic              busy;
  logic [ID_W-1:0]   cur_id;
  logic              tx_start;
  logic [7:0]        tx_din;
  logic              tx_done_tick;

  modport slave (
    input  req, din_flat, tx_done_tick,
    output ack, done, err, busy, cur_id, tx_start, tx_din
  );

  modport master (
    output req, din_flat, tx_done_tick,
    input  ack, done, err, busy, cur_id, tx_start, tx_din
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NREQ byte requesters with a WAIT timeout.
// Define UART_ARB_FIXED_PRIO_EN for fixed (lowest index) priority; round-robin otherwise.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1048575
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int ID_W  = $clog2(NREQ);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t           r_state, w_state_next;
  logic [ID_W-1:0]  r_cur_id, w_cur_id_next;
  logic [ID_W-1:0]  r_ptr, w_ptr_next;
  logic [ID_W-1:0]  w_winner, w_ptr_after;
  logic [7:0]       r_tx_din, w_tx_din_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [NREQ-1:0]  r_done, w_done_next;
  logic [NREQ-1:0]  r_err, w_err_next;
  logic [NREQ-1:0]  w_cur_onehot;
  logic [7:0]       w_bytes [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_bytes
      assign w_bytes[gi] = bus.din_flat[8*gi +: 8];
    end
  endgenerate

`ifdef UART_ARB_FIXED_PRIO_EN
  always_comb begin
    w_winner = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (bus.req[j]) w_winner = ID_W'(j);
    end
  end
`else
  logic [ID_W-1:0] w_hi_id, w_lo_id;
  logic            w_hi_found;

  // Lowest set index at or above ptr wins; otherwise wrap to the lowest set index.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_id    = '0;
    w_lo_id    = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (bus.req[j]) begin
        w_lo_id = ID_W'(j);
        if (ID_W'(j) >= r_ptr) begin
          w_hi_id    = ID_W'(j);
          w_hi_found = 1'b1;
        end
      end
    end
    w_winner = w_hi_found ? w_hi_id : w_lo_id;
  end
`endif

  assign w_cur_onehot = NREQ'(1) << r_cur_id;
  assign w_ptr_after  = (r_cur_id == ID_LAST) ? '0 : r_cur_id + ID_W'(1);

  always_comb begin
    w_state_next  = r_state;
    w_cur_id_next = r_cur_id;
    w_ptr_next    = r_ptr;
    w_tx_din_next = r_tx_din;
    w_cnt_next    = r_cnt;
    w_done_next   = '0;
    w_err_next    = '0;
    case (r_state)
      IDLE: begin
        if (|bus.req) begin
          w_cur_id_next = w_winner;
          w_tx_din_next = w_bytes[w_winner];
          w_cnt_next    = '0;
          w_state_next  = START;
        end
      end
      START: w_state_next = WAIT;
      WAIT: begin
        // A completion in the timeout cycle still counts as done.
        if (bus.tx_done_tick) begin
          w_done_next  = w_cur_onehot;
          w_ptr_next   = w_ptr_after;
          w_state_next = IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_err_next   = w_cur_onehot;
          w_ptr_next   = w_ptr_after;
          w_state_next = IDLE;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cur_id <= '0;
      r_ptr    <= '0;
      r_tx_din <= '0;
      r_cnt    <= '0;
      r_done   <= '0;
      r_err    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_cur_id <= w_cur_id_next;
      r_ptr    <= w_ptr_next;
      r_tx_din <= w_tx_din_next;
      r_cnt    <= w_cnt_next;
      r_done   <= w_done_next;
      r_err    <= w_err_next;
    end
  end

  assign bus.busy     = (r_state != IDLE);
  assign bus.tx_start = (r_state == START);
  assign bus.ack      = (r_state == START) ? w_cur_onehot : '0;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
  assign bus.cur_id   = r_cur_id;
  assign bus.tx_din   = r_tx_din;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: dut_a uses the default timeout, dut_b uses TIMEOUT=16.
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(4)) ifa ();
  uart_tx_arbiter_if #(.NREQ(4)) ifb ();

  uart_tx_arbiter #(.NREQ(4)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  uart_tx_arbiter #(.NREQ(4), .TIMEOUT(16)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

`ifdef UART_ARB_FIXED_PRIO_EN
  int exp_order [5] = '{0, 0, 0, 0, 0};
  int exp_after_to = 0;
`else
  int exp_order [5] = '{0, 1, 2, 3, 0};
  int exp_after_to = 3;
`endif

  initial begin
    reset = 1'b1;
    ifa.req = '0; ifa.din_flat = '0; ifa.tx_done_tick = 1'b0;
    ifb.req = '0; ifb.din_flat = '0; ifb.tx_done_tick = 1'b0;
    step();
    step();
    chk("rst_busy",     32'(ifa.busy),     0);
    chk("rst_tx_start", 32'(ifa.tx_start), 0);
    chk("rst_ack",      32'(ifa.ack),      0);
    chk("rst_done",     32'(ifa.done),     0);
    chk("rst_err",      32'(ifa.err),      0);
    chk("rst_cur_id",   32'(ifa.cur_id),   0);
    chk("rst_tx_din",   32'(ifa.tx_din),   0);
    reset = 1'b0;

    // Single byte from requester 0, completion 100 cycles after tx_start
    ifa.din_flat = 32'h0000_0055;
    ifa.req      = 4'b0001;
    step();
    chk("t1_tx_start", 32'(ifa.tx_start), 1);
    chk("t1_ack",      32'(ifa.ack),      'h1);
    chk("t1_tx_din",   32'(ifa.tx_din),   'h55);
    chk("t1_busy",     32'(ifa.busy),     1);
    ifa.req = 4'b0000;
    step();
    chk("t1_start_1cyc", 32'(ifa.tx_start), 0);
    chk("t1_ack_1cyc",   32'(ifa.ack),      0);
    chk("t1_busy_wait",  32'(ifa.busy),     1);
    for (int i = 0; i < 99; i++) step();
    chk("t1_no_early_done", 32'(ifa.done), 0);
    ifa.tx_done_tick = 1'b1;
    step();
    ifa.tx_done_tick = 1'b0;
    chk("t1_done",      32'(ifa.done),   'h1);
    chk("t1_busy_idle", 32'(ifa.busy),   0);
    chk("t1_din_hold",  32'(ifa.tx_din), 'h55);
    $display("xfer dut_a id=%0d byte=0x%02h done=%b", ifa.cur_id, ifa.tx_din, ifa.done);
    step();
    chk("t1_done_pulse", 32'(ifa.done), 0);

    // Stray tx_done_tick while idle
    ifa.tx_done_tick = 1'b1;
    step();
    ifa.tx_done_tick = 1'b0;
    chk("idle_tick_busy", 32'(ifa.busy), 0);
    chk("idle_tick_done", 32'(ifa.done), 0);
    step();
    chk("idle_tick_done2", 32'(ifa.done),     0);
    chk("idle_tick_start", 32'(ifa.tx_start), 0);

    // All four requesting, back-to-back transfers
    reset = 1'b1;
    step();
    reset = 1'b0;
    ifa.din_flat = 32'h4433_2211;
    ifa.req      = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_tx_start", 32'(ifa.tx_start), 1);
      chk("rr_cur_id",   32'(ifa.cur_id),   32'(exp_order[k]));
      chk("rr_ack",      32'(ifa.ack),      32'(1) << exp_order[k]);
      chk("rr_tx_din",   32'(ifa.tx_din),   32'h11 * 32'(exp_order[k] + 1));
      step();
      ifa.tx_done_tick = 1'b1;
      step();
      ifa.tx_done_tick = 1'b0;
      chk("rr_done", 32'(ifa.done), 32'(1) << exp_order[k]);
      chk("rr_busy", 32'(ifa.busy), 0);
      $display("xfer dut_a id=%0d byte=0x%02h done=%b", ifa.cur_id, ifa.tx_din, ifa.done);
    end
    ifa.req = 4'b0000;
    step();
    chk("rr_idle", 32'(ifa.busy), 0);

    // din_flat changes during WAIT must not reach tx_din
    ifa.din_flat[15:8] = 8'hA5;
    ifa.req = 4'b0010;
    step();
    chk("hold_cur_id", 32'(ifa.cur_id), 1);
    chk("hold_din0",   32'(ifa.tx_din), 'hA5);
    step();
    ifa.req = 4'b0000;
    ifa.din_flat[15:8] = 8'h3C;
    step();
    step();
    chk("hold_din_wait", 32'(ifa.tx_din), 'hA5);
    ifa.tx_done_tick = 1'b1;
    step();
    ifa.tx_done_tick = 1'b0;
    chk("hold_done",     32'(ifa.done),   'h2);
    chk("hold_din_done", 32'(ifa.tx_din), 'hA5);
    $display("xfer dut_a id=%0d byte=0x%02h done=%b", ifa.cur_id, ifa.tx_din, ifa.done);

    // Reset 5 cycles into WAIT for requester 2
    ifa.din_flat[23:16] = 8'h77;
    ifa.req = 4'b0100;
    step();
    chk("rstw_cur_id", 32'(ifa.cur_id), 2);
    ifa.req = 4'b0000;
    step();
    for (int i = 0; i < 4; i++) step();
    chk("rstw_busy_pre", 32'(ifa.busy), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstw_busy",   32'(ifa.busy),     0);
    chk("rstw_done",   32'(ifa.done),     0);
    chk("rstw_err",    32'(ifa.err),      0);
    chk("rstw_cur_id0", 32'(ifa.cur_id),  0);
    chk("rstw_tx_din", 32'(ifa.tx_din),   0);
    chk("rstw_start",  32'(ifa.tx_start), 0);
    $display("xfer dut_a id=2 killed by reset");
    step();
    chk("rstw_done_late", 32'(ifa.done), 0);
    chk("rstw_err_late",  32'(ifa.err),  0);
    ifa.req = 4'b1010;
    step();
    chk("rstw_next_grant", 32'(ifa.cur_id), 1);
    ifa.req = 4'b0000;
    step();
    ifa.tx_done_tick = 1'b1;
    step();
    ifa.tx_done_tick = 1'b0;
    chk("rstw_next_done", 32'(ifa.done), 'h2);

    // Timeout on dut_b (TIMEOUT=16) for requester 2
    ifb.din_flat = 32'h0099_0000;
    ifb.req = 4'b0100;
    step();
    chk("to_tx_start", 32'(ifb.tx_start), 1);
    chk("to_ack",      32'(ifb.ack),      'h4);
    ifb.req = 4'b0000;
    step();
    chk("to_busy_w0", 32'(ifb.busy), 1);
    for (int i = 0; i < 15; i++) begin
      step();
      chk("to_no_err_early", 32'(ifb.err),  0);
      chk("to_busy_wait",    32'(ifb.busy), 1);
    end
    step();
    chk("to_err",  32'(ifb.err),  'h4);
    chk("to_done", 32'(ifb.done), 0);
    chk("to_busy", 32'(ifb.busy), 0);
    $display("xfer dut_b id=%0d byte=0x%02h err=%b", ifb.cur_id, ifb.tx_din, ifb.err);
    ifb.req = 4'b1011;
    step();
    chk("to_ptr_grant",  32'(ifb.cur_id),   32'(exp_after_to));
    chk("to_err_pulse",  32'(ifb.err),      0);
    chk("to_next_start", 32'(ifb.tx_start), 1);

    // Completion in the same cycle as the timeout: done wins
    ifb.req = 4'b0000;
    step();
    for (int i = 0; i < 15; i++) step();
    ifb.tx_done_tick = 1'b1;
    step();
    ifb.tx_done_tick = 1'b0;
    chk("tie_done", 32'(ifb.done), 32'(1) << exp_after_to);
    chk("tie_err",  32'(ifb.err),  0);
    $display("xfer dut_b id=%0d byte=0x%02h done=%b", ifb.cur_id, ifb.tx_din, ifb.done);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
